// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and strobe bundle for the CPU controller
package cpu_pkg;

   localparam int OPCODE_W = 5;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t OP_LD   = 5'b00000;
   localparam opcode_t OP_LDI  = 5'b00001;
   localparam opcode_t OP_ST   = 5'b00010;
   localparam opcode_t OP_ADD  = 5'b00011;
   localparam opcode_t OP_SUB  = 5'b00100;
   localparam opcode_t OP_AND  = 5'b00101;
   localparam opcode_t OP_OR   = 5'b00110;
   localparam opcode_t OP_ADDI = 5'b01100;
   localparam opcode_t OP_ANDI = 5'b01101;
   localparam opcode_t OP_ORI  = 5'b01110;
   localparam opcode_t OP_BR   = 5'b10010;
   localparam opcode_t OP_JR   = 5'b10011;
   localparam opcode_t OP_IN   = 5'b10110;
   localparam opcode_t OP_OUT  = 5'b10111;
   localparam opcode_t OP_NOP  = 5'b11010;
   localparam opcode_t OP_HALT = 5'b11011;

   localparam opcode_t ALU_ADD = OP_ADD;

   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT, PAUSE} state_t;

   typedef struct packed {
      logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortOut;
      logic PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn, RAMin;
      logic IncPC, Read, GRA, GRB, GRC;
   } strobes_t;

   // Last execute step of each instruction; T2 covers nop, halt and undefined opcodes.
   function automatic state_t final_step(input opcode_t op);
      case (op)
         OP_LD, OP_ST:                                  final_step = T7;
         OP_BR:                                         final_step = T6;
         OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ADDI, OP_ANDI, OP_ORI:                      final_step = T5;
         OP_JR, OP_IN, OP_OUT:                          final_step = T3;
         default:                                       final_step = T2;
      endcase
   endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational decode of (state, opcode, CON) into datapath strobes
module control_decode
   import cpu_pkg::*;
(
   input  state_t   state,
   input  opcode_t  opcode,
   input  logic     con,
   output strobes_t strb,
   output opcode_t  alu_op,
   output logic     run
);

   logic addr_op, reg_alu, imm_alu, br_op;

   assign addr_op = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
   assign reg_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_OR);
   assign imm_alu = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
   assign br_op   = (opcode == OP_BR);

   always_comb begin
      strb   = '0;
      alu_op = opcode;
      run    = 1'b1;
      // Effective-address and branch-target arithmetic always adds.
      if ((state inside {T3, T4, T5, T6, T7}) && (addr_op || br_op))
         alu_op = ALU_ADD;
      case (state)
         RST, HALT, PAUSE: begin
            run    = 1'b0;
            alu_op = '0;
         end
         T0: begin
            strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncPC = 1'b1; strb.ZLowIn = 1'b1;
            alu_op = ALU_ADD;
         end
         T1: begin
            strb.ZLowout = 1'b1; strb.PCin = 1'b1; strb.Read = 1'b1; strb.MDRin = 1'b1;
         end
         T2: begin
            strb.MDRout = 1'b1; strb.IRin = 1'b1;
         end
         T3: begin
            if (addr_op) begin
               strb.GRB = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1;
            end else if (reg_alu || imm_alu) begin
               strb.GRB = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1;
            end else if (br_op) begin
               strb.GRA = 1'b1; strb.Rout = 1'b1; strb.CONin = 1'b1;
            end else if (opcode == OP_JR) begin
               strb.GRA = 1'b1; strb.Rout = 1'b1; strb.PCin = 1'b1;
            end else if (opcode == OP_IN) begin
               strb.InPortOut = 1'b1; strb.GRA = 1'b1; strb.Rin = 1'b1;
            end else if (opcode == OP_OUT) begin
               strb.GRA = 1'b1; strb.Rout = 1'b1; strb.OutPortIn = 1'b1;
            end
         end
         T4: begin
            if (addr_op || imm_alu) begin
               strb.Cout = 1'b1; strb.ZLowIn = 1'b1;
            end else if (reg_alu) begin
               strb.GRC = 1'b1; strb.Rout = 1'b1; strb.ZLowIn = 1'b1;
            end else if (br_op) begin
               strb.PCout = 1'b1; strb.Yin = 1'b1;
            end
         end
         T5: begin
            if (opcode == OP_LD || opcode == OP_ST) begin
               strb.ZLowout = 1'b1; strb.MARin = 1'b1;
            end else if (opcode == OP_LDI || reg_alu || imm_alu) begin
               strb.ZLowout = 1'b1; strb.GRA = 1'b1; strb.Rin = 1'b1;
            end else if (br_op) begin
               strb.Cout = 1'b1; strb.ZLowIn = 1'b1;
            end
         end
         T6: begin
            if (opcode == OP_LD) begin
               strb.Read = 1'b1; strb.MDRin = 1'b1;
            end else if (opcode == OP_ST) begin
               strb.GRA = 1'b1; strb.Rout = 1'b1; strb.MDRin = 1'b1;
            end else if (br_op && con) begin
               strb.ZLowout = 1'b1; strb.PCin = 1'b1;
            end
         end
         T7: begin
            if (opcode == OP_LD) begin
               strb.MDRout = 1'b1; strb.GRA = 1'b1; strb.Rin = 1'b1;
            end else if (opcode == OP_ST) begin
               strb.MDRout = 1'b1; strb.RAMin = 1'b1;
            end
         end
         default: begin
            run    = 1'b0;
            alu_op = '0;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore sequencer for the single-bus CPU datapath
module control_unit
   import cpu_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic                Clock,
   input  logic                Clear,
   input  logic [31:0]         IR,
   input  logic                CON,
   input  logic                Mem_ready,
   input  logic                Stop,
   output logic                PCout, ZLowout, ZHighout, MDRout, HIout,
   output logic                LOout, Cout, BAout, Rout, InPortOut,
   output logic                PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn,
   output logic                HIin, LOin, Rin, CONin, OutPortIn, RAMin,
   output logic                IncPC, Read, GRA, GRB, GRC,
   output logic [OPCODE_W-1:0] Alu_op,
   output logic                Run,
   output logic                Mem_err
);

   localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

   state_t     state, next_state;
   logic [CNT_W-1:0] wait_cnt;
   opcode_t    opcode;
   strobes_t   strb;
   logic       mem_step, timeout;
   logic       unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   assign mem_step = (state == T1) || (state == T6 && opcode == OP_LD) || (state == T7 && opcode == OP_ST);
   assign timeout  = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

   always_comb begin
      next_state = state;
      case (state)
         RST:   next_state = T0;
         HALT:  next_state = HALT;
         PAUSE: next_state = Stop ? PAUSE : T0;
         default: begin
            if (state == T2 && opcode == OP_HALT)
               next_state = HALT;
            else if (state == final_step(opcode))
               next_state = Stop ? PAUSE : T0;
            else
               next_state = state_t'(state + 4'd1);
         end
      endcase
   end

   // Mem_ready is checked before the timeout so a late-but-in-time reply still succeeds.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state    <= RST;
         wait_cnt <= '0;
         Mem_err  <= 1'b0;
      end else if (mem_step && !Mem_ready) begin
         if (timeout) begin
            state    <= HALT;
            Mem_err  <= 1'b1;
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end else begin
         state    <= next_state;
         wait_cnt <= '0;
      end
   end

   control_decode u_decode (
      .state  (state),
      .opcode (opcode),
      .con    (CON),
      .strb   (strb),
      .alu_op (Alu_op),
      .run    (Run)
   );

   assign PCout     = strb.PCout;
   assign ZLowout   = strb.ZLowout;
   assign ZHighout  = strb.ZHighout;
   assign MDRout    = strb.MDRout;
   assign HIout     = strb.HIout;
   assign LOout     = strb.LOout;
   assign Cout      = strb.Cout;
   assign BAout     = strb.BAout;
   assign Rout      = strb.Rout;
   assign InPortOut = strb.InPortOut;
   assign PCin      = strb.PCin;
   assign MARin     = strb.MARin;
   assign MDRin     = strb.MDRin;
   assign IRin      = strb.IRin;
   assign Yin       = strb.Yin;
   assign ZLowIn    = strb.ZLowIn;
   assign ZHighIn   = strb.ZHighIn;
   assign HIin      = strb.HIin;
   assign LOin      = strb.LOin;
   assign Rin       = strb.Rin;
   assign CONin     = strb.CONin;
   assign OutPortIn = strb.OutPortIn;
   assign RAMin     = strb.RAMin;
   assign IncPC     = strb.IncPC;
   assign Read      = strb.Read;
   assign GRA       = strb.GRA;
   assign GRB       = strb.GRB;
   assign GRC       = strb.GRC;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore-style controller that sequences the single-bus CPU datapath.
- Fetches each instruction: T0 sends PC to MAR, T1 reads memory into MDR, T2 loads IR.
- Decodes IR[31:27] and drives every datapath control strobe for T3..T7.
- Sits beside the datapath: consumes IR, CON and the memory-ready handshake; produces all In/out/select strobes and the ALU operation.

Parameters:
- OPCODE_W, 5, opcode field width (IR[31:27]).
- WAIT_LIMIT, 15, maximum cycles any memory step may wait for Mem_ready before a fault.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents from the datapath.
- CON  in  1  branch-condition flip-flop output.
- Mem_ready  in  1  memory has completed the current Read/RAMin access.
- Stop  in  1  request to pause at the next instruction boundary.
- PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortOut  out  1 each  bus drivers.
- PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn, RAMin  out  1 each  register and memory write enables.
- IncPC, Read, GRA, GRB, GRC  out  1 each  PC increment, memory read, register-field selects.
- Alu_op  out  OPCODE_W  operation presented to the ALU.
- Run  out  1  high while the controller is executing instructions.
- Mem_err  out  1  sticky memory-timeout fault flag.

Behaviour:
- Reset:
  - Clear=1 at a rising edge moves the FSM to RST from any state, including mid-instruction or mid-wait.
  - In RST all strobes=0, Alu_op=0, Run=0; Mem_err and the wait counter are cleared.
  - The state after RST is T0.
- Outputs are decoded from the state register only, except the T6 branch step, which also uses CON.
- Run=1 in every state except RST, HALT and PAUSE.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: ZLowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Memory wait:
  - Applies to every step that asserts Read (T1, ld T6) or RAMin (st T7).
  - The FSM stays in that step, holding all strobes, until Mem_ready=1, then advances on that edge.
  - A wait counter increments once per waiting cycle.
  - Reaching WAIT_LIMIT sets Mem_err and enters HALT.
- Default ALU: Alu_op = ADD (00011) in address and branch-target steps; otherwise Alu_op = IR opcode.
- Execute sequences (T3 onward; after the final step, T0 follows):
  - ld (00000):
    - T3: GRB, BAout, Yin.
    - T4: Cout, ZLowIn.
    - T5: ZLowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, GRA, Rin.
  - ldi (00001): T3–T4 as ld; T5: ZLowout, GRA, Rin.
  - st (00010):
    - T3–T5 as ld.
    - T6: GRA, Rout, MDRin.
    - T7: MDRout, RAMin.
  - add, sub, and, or (00011–00110):
    - T3: GRB, Rout, Yin.
    - T4: GRC, Rout, ZLowIn.
    - T5: ZLowout, GRA, Rin.
  - addi, andi, ori (01100–01110):
    - T3: GRB, Rout, Yin.
    - T4: Cout, ZLowIn.
    - T5: ZLowout, GRA, Rin.
  - br (10010):
    - T3: GRA, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, ZLowIn.
    - T6: ZLowout and PCin only if CON=1; otherwise no strobes.
  - jr (10011): T3: GRA, Rout, PCin.
  - in (10110): T3: InPortOut, GRA, Rin.
  - out (10111): T3: GRA, Rout, OutPortIn.
  - nop (11010) and any undefined opcode: T2 goes directly to T0.
  - halt (11011): T2 goes to HALT.
- HALT:
  - All strobes 0, Run=0.
  - Only Clear exits.
- Stop:
  - Sampled only at instruction end (the transition to T0). If Stop=1 there, enter PAUSE.
  - PAUSE holds all strobes 0 and returns to T0 once Stop=0.
  - Stop asserted mid-instruction never truncates the instruction.
- Simultaneous events: Clear overrides Stop, Mem_ready and the timeout, in that order. A timeout reached on the same cycle Mem_ready rises counts as success.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_LD … OP_HALT);
  - the state enum (RST, T0–T7, HALT, PAUSE);
  - the ADD Alu_op constant.
- One sub-module, control_decode: purely combinational (state, opcode, CON) → strobe vector.
- The control_unit top holds the state register, wait counter, Stop/HALT logic and Mem_err.

Test Plan:
- Clear for 2 cycles, then release, Mem_ready tied 1 -> all strobes 0 during Clear; T0 strobes (PCout, MARin, IncPC, ZLowIn) on the first cycle after release; Run=1.
- IR=32'h09000005 (ldi R2,5) -> after the T0–T2 fetch, T3 GRB/BAout/Yin, T4 Cout/ZLowIn with Alu_op=00011, T5 ZLowout/GRA/Rin, then T0; 6 cycles total.
- ld with Mem_ready delayed 3 cycles in T6 -> Read/MDRin held for 4 cycles; Mem_err=0; T7 MDRout/GRA/Rin.
- br with CON=0, then the same br with CON=1 -> T6 shows no PCin in the first case; ZLowout+PCin in the second.
- Mem_ready held 0 in T1 -> after 15 wait cycles Mem_err=1, Run=0, FSM in HALT; Clear then clears Mem_err.
- Stop=1 asserted during T4 of an add -> the add completes T5; FSM enters PAUSE; deasserting Stop resumes at T0.
